// File: rtl/instructions_pkg.sv
// Shared instruction-level types used across the core.
package instructions_pkg;

    typedef logic [31:0] arch_reg;

endpackage

// File: rtl/reg_file_pkg.sv
// Register-file configuration constants and index/counter types.
package reg_file_pkg;

    localparam int NUM_REGS = 32;
    localparam int PEND_W   = 2;

    typedef logic [4:0]        reg_addr_t;
    typedef logic [PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters, issue back-pressure and sticky underflow flag.
// Build option REG_FILE_BYPASS_EN: busy reflects a same-cycle write-back decrement.
module reg_scoreboard #(
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int PEND_W   = reg_file_pkg::PEND_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_en,
    input  logic [4:0] issue_rd,
    input  logic       wb_en,
    input  logic [4:0] wb_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       issue_ready,
    output logic       wb_underflow
);
    import reg_file_pkg::*;

    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);

    logic [PEND_W-1:0] cnt_r     [NUM_REGS];
    logic [PEND_W-1:0] cnt_nxt_s [NUM_REGS];
    logic [PEND_W-1:0] issue_cnt_s, wb_cnt_s, rs1_cnt_s, rs2_cnt_s;
    logic              issue_acc_s, wb_hit_s, underflow_r;

    // Counter lookup for each port; x0 is skipped so it always reads as zero
    always_comb begin
        issue_cnt_s = CNT_ZERO;
        wb_cnt_s    = CNT_ZERO;
        rs1_cnt_s   = CNT_ZERO;
        rs2_cnt_s   = CNT_ZERO;
        for (int i = 1; i < NUM_REGS; i++) begin
            issue_cnt_s = (issue_rd == reg_addr_t'(i)) ? cnt_r[i] : issue_cnt_s;
            wb_cnt_s    = (wb_addr  == reg_addr_t'(i)) ? cnt_r[i] : wb_cnt_s;
            rs1_cnt_s   = (rs1_addr == reg_addr_t'(i)) ? cnt_r[i] : rs1_cnt_s;
            rs2_cnt_s   = (rs2_addr == reg_addr_t'(i)) ? cnt_r[i] : rs2_cnt_s;
        end
    end

    // Issue acceptance, write-back qualification and busy reporting
    always_comb begin
        issue_ready = (issue_cnt_s != CNT_MAX);
        issue_acc_s = issue_en & issue_ready & (issue_rd != 5'd0);
        wb_hit_s    = wb_en & (wb_addr != 5'd0);
`ifdef REG_FILE_BYPASS_EN
        rs1_busy = (rs1_cnt_s != CNT_ZERO) &&
                   !(wb_hit_s && (wb_addr == rs1_addr) && (rs1_cnt_s == CNT_ONE));
        rs2_busy = (rs2_cnt_s != CNT_ZERO) &&
                   !(wb_hit_s && (wb_addr == rs2_addr) && (rs2_cnt_s == CNT_ONE));
`else
        rs1_busy = (rs1_cnt_s != CNT_ZERO);
        rs2_busy = (rs2_cnt_s != CNT_ZERO);
`endif
    end

    // Next counter values; a decrement at zero holds zero instead of wrapping
    always_comb begin
        logic inc_s;
        logic dec_s;
        inc_s = 1'b0;
        dec_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_s = issue_acc_s && (issue_rd == reg_addr_t'(i));
            dec_s = wb_hit_s && (wb_addr == reg_addr_t'(i));
            case ({inc_s, dec_s})
                2'b10:   cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                2'b01:   cnt_nxt_s[i] = (cnt_r[i] == CNT_ZERO) ? CNT_ZERO : cnt_r[i] - CNT_ONE;
                default: cnt_nxt_s[i] = cnt_r[i];
            endcase
        end
    end

    // Counter and sticky underflow state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            underflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            underflow_r <= underflow_r | (wb_hit_s && (wb_cnt_s == CNT_ZERO));
        end
    end

    assign wb_underflow = underflow_r;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with per-register pending-write scoreboard.
// Build option REG_FILE_BYPASS_EN: write-back data is forwarded to the read ports in the same cycle.
module reg_file_sb import instructions_pkg::*; #(
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int PEND_W   = reg_file_pkg::PEND_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output arch_reg    rs1_data,
    output arch_reg    rs2_data,
    output logic       rs1_busy,
    output logic       rs2_busy,
    input  logic       wb_en,
    input  logic [4:0] wb_addr,
    input  arch_reg    wb_data,
    input  logic       issue_en,
    input  logic [4:0] issue_rd,
    output logic       issue_ready,
    output logic       wb_underflow
);
    import reg_file_pkg::*;

    arch_reg data_r [NUM_REGS];
    arch_reg rs1_arr_s, rs2_arr_s;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .issue_ready  (issue_ready),
        .wb_underflow (wb_underflow)
    );

    // Array read; x0 is never looked up so it always reads as zero
    always_comb begin
        rs1_arr_s = 32'h0000_0000;
        rs2_arr_s = 32'h0000_0000;
        for (int i = 1; i < NUM_REGS; i++) begin
            rs1_arr_s = (rs1_addr == reg_addr_t'(i)) ? data_r[i] : rs1_arr_s;
            rs2_arr_s = (rs2_addr == reg_addr_t'(i)) ? data_r[i] : rs2_arr_s;
        end
    end

    // Read-port output selection, forwarding write-back data when bypass is built in
    always_comb begin
`ifdef REG_FILE_BYPASS_EN
        if (!rst && wb_en && (wb_addr != 5'd0) && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = rs1_arr_s;
        end
        if (!rst && wb_en && (wb_addr != 5'd0) && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = rs2_arr_s;
        end
`else
        rs1_data = rs1_arr_s;
        rs2_data = rs2_arr_s;
`endif
    end

    // Data array write; writes to x0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb_en && (wb_addr == reg_addr_t'(i))) begin
                    data_r[i] <= wb_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-style randomized bench for reg_file_sb against a behavioural register/pending model.
module tb_reg_file_sb;

    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'h0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_ready, wb_underflow;

    reg_file_sb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d1, d2;
        logic        b1, b2, rdy, uf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: architectural values and outstanding-write counts
    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_uflow;

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit we, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a, input bit we, input logic [4:0] wa);
        int p;
        if (a == 5'd0) return 1'b0;
        p = m_pend[a];
`ifdef REG_FILE_BYPASS_EN
        if (we && wa == a && p > 0) p = p - 1;
`endif
        return p > 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit ie, input logic [4:0] ird, input bit we_in,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        bit   we, acc;
        we = we_in;
        // same-index issue and write-back against an idle counter is kept out of the stimulus
        if (!r && ie && we && ird == wa && wa != 5'd0 && m_pend[wa] == 0) we = 1'b0;
        @(posedge clk);
        #1;
        rst = r; issue_en = ie; issue_rd = ird; wb_en = we; wb_addr = wa; wb_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 0;
            end
            m_uflow = 1'b0;
            e = '{d1: 32'h0, d2: 32'h0, b1: 1'b0, b2: 1'b0, rdy: 1'b1, uf: 1'b0};
        end else begin
            e.d1  = m_read(a1, we && wa != 5'd0, wa, wd);
            e.d2  = m_read(a2, we && wa != 5'd0, wa, wd);
            e.b1  = m_busy(a1, we && wa != 5'd0, wa);
            e.b2  = m_busy(a2, we && wa != 5'd0, wa);
            e.rdy = (m_pend[ird] < PMAX);
            e.uf  = m_uflow;
            acc = ie && ird != 5'd0 && m_pend[ird] < PMAX;
            if (we && wa != 5'd0) begin
                m_regs[wa] = wd;
                if (m_pend[wa] > 0) m_pend[wa] = m_pend[wa] - 1;
                else m_uflow = 1'b1;
            end
            if (acc) m_pend[ird] = m_pend[ird] + 1;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output set against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rs1_data", rs1_data, e.d1);
            check("rs2_data", rs2_data, e.d2);
            check("rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1});
            check("rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2});
            check("issue_ready", {31'd0, issue_ready}, {31'd0, e.rdy});
            check("wb_underflow", {31'd0, wb_underflow}, {31'd0, e.uf});
        end
    end

    logic [4:0] pick [6];

    initial begin
        pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd3;
        pick[3] = 5'd5; pick[4] = 5'd7; pick[5] = 5'd9;

        drive(1, 1, 5'd5, 1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd7);
        drive(1, 1, 5'd7, 1, 5'd7, 32'h1111_1111, 5'd7, 5'd5);
        drive(0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd5, 5'd0);
        drive(0, 1, 5'd5, 0, 5'd0, 32'h0, 5'd5, 5'd0);
        drive(0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        drive(0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd5, 5'd0);
        for (int k = 0; k < 4; k++) drive(0, 1, 5'd7, 0, 5'd0, 32'h0, 5'd7, 5'd5);
        drive(0, 0, 5'd7, 1, 5'd7, 32'h7777_7777, 5'd7, 5'd0);
        drive(0, 0, 5'd7, 0, 5'd0, 32'h0, 5'd7, 5'd0);
        drive(0, 1, 5'd9, 0, 5'd0, 32'h0, 5'd9, 5'd7);
        drive(0, 1, 5'd9, 1, 5'd9, 32'h55AA_55AA, 5'd9, 5'd0);
        drive(0, 0, 5'd9, 0, 5'd0, 32'h0, 5'd9, 5'd0);
        drive(0, 1, 5'd0, 1, 5'd0, 32'h0000_1234, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd9);
        drive(0, 0, 5'd0, 1, 5'd3, 32'h3333_3333, 5'd3, 5'd0);
        drive(0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd3, 5'd7);
        drive(0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd3, 5'd9);
        drive(1, 1, 5'd3, 1, 5'd3, 32'hABCD_0000, 5'd3, 5'd7);
        drive(0, 0, 5'd7, 0, 5'd0, 32'h0, 5'd3, 5'd7);

        for (int k = 0; k < 500; k++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                  pick[$urandom_range(0, 5)], $urandom_range(0, 2) == 0,
                  pick[$urandom_range(0, 5)], $urandom,
                  pick[$urandom_range(0, 5)], pick[$urandom_range(0, 5)]);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
